// File: rtl/tc_device_if.sv
// Data-memory bus between the memory stage (master) and a timer/counter responder (slave).
interface tc_device_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, byteen, wdata, input rdata, irq);
  modport slave  (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/tc_device.sv
// Memory-mapped timer/counter: CTRL/PRESET/COUNT in a 16-byte window, maskable interrupt
// to CP0 HWInt, one-shot and periodic modes.
module tc_device #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  tc_device_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  localparam logic [1:0] OFF_CTRL      = 2'd0;
  localparam logic [1:0] OFF_PRESET    = 2'd1;
  localparam logic [1:0] OFF_COUNT     = 2'd2;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  state_t      state, state_next;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_r;

  logic hit, we, we_ctrl, we_preset;
  logic load_count, dec_count, expire, irq_clear, en_clear;
  logic unused_addr_bits;

  assign hit       = (bus.addr[31:4] == BASE[31:4]);
  assign we        = hit && (bus.byteen == 4'b1111);
  assign we_ctrl   = we && (bus.addr[3:2] == OFF_CTRL);
  assign we_preset = we && (bus.addr[3:2] == OFF_PRESET);
  assign unused_addr_bits = ^bus.addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // EN is sampled from the live CTRL register, so a CTRL write never forces a state change.
  always_comb begin
    state_next = state;
    load_count = 1'b0;
    dec_count  = 1'b0;
    expire     = 1'b0;
    irq_clear  = 1'b0;
    en_clear   = 1'b0;
    case (state)
      IDLE: if (ctrl[0]) state_next = LOAD;
      LOAD: begin
        load_count = 1'b1;
        state_next = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_next = IDLE;
        end else if (count > 32'd1) begin
          dec_count = 1'b1;
        end else begin
          expire     = 1'b1;
          state_next = INT;
        end
      end
      INT: begin
        if (ctrl[2:1] == MODE_PERIODIC) irq_clear = 1'b1;
        else                            en_clear  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A CTRL write outranks every FSM-driven update of EN and irq_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      irq_r  <= 1'b0;
    end else begin
      if (we_ctrl)       ctrl    <= bus.wdata[3:0];
      else if (en_clear) ctrl[0] <= 1'b0;

      if (we_preset) preset <= bus.wdata;

      if (load_count)     count <= preset;
      else if (dec_count) count <= count - 32'd1;
      else if (expire)    count <= 32'd0;

      if (we_ctrl)        irq_r <= 1'b0;
      else if (expire)    irq_r <= 1'b1;
      else if (irq_clear) irq_r <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      case (bus.addr[3:2])
        OFF_CTRL:   bus.rdata = {28'd0, ctrl};
        OFF_PRESET: bus.rdata = preset;
        OFF_COUNT:  bus.rdata = count;
        default:    bus.rdata = 32'd0;
      endcase
    end
  end

  assign bus.irq = irq_r & ctrl[3];

endmodule

// File: tb/tb_tc_device.sv
// Directed scoreboard bench for tc_device: expectations are queued as stimulus is applied
// and popped against the bus outputs one cycle at a time.
module tb_tc_device;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_UNMAP  = BASE + 32'hC;

  logic clk = 1'b0;
  logic reset;

  tc_device_if bus ();

  tc_device #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_irq;
    logic [31:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reg(input string tag, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b0; e.addr = a; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_irq(input string tag, input bit v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b1; e.addr = A_UNMAP; e.exp = {31'd0, v};
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare it with what the DUT presents right now.
  task automatic checkOutput;
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.byteen = 4'b0000;
      if (!e.is_irq) bus.addr = e.addr;
      #1;
      obs = e.is_irq ? {31'd0, bus.irq} : bus.rdata;
      n_checks++;
      assert (obs === e.exp) n_pass++;
      else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
    end
  endtask

  // One bus store; the sampling edge is the write edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr   = a;
    bus.wdata  = d;
    bus.byteen = be;
    tick;
    bus.byteen = 4'b0000;
    bus.addr   = A_UNMAP;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    bit found;

    bus.addr   = A_UNMAP;
    bus.byteen = 4'b0000;
    bus.wdata  = 32'd0;
    reset      = 1'b1;
    repeat (3) tick;
    reset = 1'b0;

    $display("[TB] reset state");
    expect_reg("rst_ctrl",   A_CTRL,   32'd0);
    expect_reg("rst_preset", A_PRESET, 32'd0);
    expect_reg("rst_count",  A_COUNT,  32'd0);
    expect_reg("rst_unmap",  A_UNMAP,  32'd0);
    checkOutput;
    for (int c = 0; c < 20; c++) begin
      expect_irq($sformatf("rst_irq_c%0d", c), 1'b0);
      checkOutput;
      tick;
    end

    $display("[TB] one-shot PRESET=3");
    applyStimulus(A_PRESET, 32'd3, 4'hF);
    applyStimulus(A_CTRL, 32'd9, 4'hF);
    tick;
    for (int k = 2; k <= 5; k++) begin
      tick;
      expect_reg($sformatf("os_count_e%0d", k), A_COUNT, 32'(5 - k));
      expect_irq($sformatf("os_irq_e%0d", k), k == 5);
      checkOutput;
    end
    tick;
    expect_reg("os_ctrl_e6", A_CTRL, 32'd8);
    expect_irq("os_irq_e6", 1'b1);
    checkOutput;
    tick;
    expect_irq("os_irq_e7", 1'b1);
    checkOutput;
    applyStimulus(A_CTRL, 32'd0, 4'hF);
    expect_irq("os_irq_cleared", 1'b0);
    expect_reg("os_ctrl_cleared", A_CTRL, 32'd0);
    checkOutput;

    $display("[TB] periodic PRESET=3");
    applyStimulus(A_PRESET, 32'd3, 4'hF);
    applyStimulus(A_CTRL, 32'hB, 4'hF);
    for (int c = 1; c <= 26; c++) begin
      tick;
      expect_irq($sformatf("per_irq_e%0d", c), (c >= 5) && ((c - 5) % 6 == 0));
      checkOutput;
    end
    applyStimulus(A_CTRL, 32'd0, 4'hF);
    repeat (3) tick;
    expect_irq("per_irq_stopped", 1'b0);
    checkOutput;

    $display("[TB] masked interrupt");
    applyStimulus(A_PRESET, 32'd2, 4'hF);
    applyStimulus(A_CTRL, 32'd1, 4'hF);
    for (int c = 1; c <= 6; c++) begin
      tick;
      expect_irq($sformatf("mask_irq_e%0d", c), 1'b0);
      checkOutput;
    end
    expect_reg("mask_ctrl_done",  A_CTRL,  32'd0);
    expect_reg("mask_count_done", A_COUNT, 32'd0);
    checkOutput;
    applyStimulus(A_CTRL, 32'd8, 4'hF);
    expect_reg("mask_ctrl_im", A_CTRL, 32'd8);
    expect_irq("mask_irq_im", 1'b0);
    checkOutput;
    tick;
    expect_irq("mask_irq_im_next", 1'b0);
    checkOutput;
    applyStimulus(A_CTRL, 32'd0, 4'hF);

    $display("[TB] ignored writes");
    applyStimulus(A_COUNT, 32'h0000_1234, 4'hF);
    expect_reg("ign_count_sw", A_COUNT, 32'd0);
    checkOutput;
    applyStimulus(A_PRESET, 32'hDEAD_BEEF, 4'b0011);
    expect_reg("ign_preset_partial", A_PRESET, 32'd2);
    checkOutput;
    applyStimulus(BASE + 32'h20, 32'h0000_000F, 4'hF);
    expect_reg("ign_far_ctrl",   A_CTRL,         32'd0);
    expect_reg("ign_far_preset", A_PRESET,       32'd2);
    expect_reg("ign_nohit_read", BASE + 32'h24,  32'd0);
    checkOutput;
    repeat (3) tick;
    expect_reg("ign_far_no_start", A_COUNT, 32'd0);
    checkOutput;

    $display("[TB] disable mid-count");
    applyStimulus(A_PRESET, 32'd10, 4'hF);
    applyStimulus(A_CTRL, 32'd1, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      bus.addr = A_COUNT;
      #1;
      if (bus.rdata == 32'd6) found = 1'b1;
      else tick;
    end
    n_checks++;
    assert (found) n_pass++;
    else $error("[TB] FAIL dis_poll: observed no COUNT=6 expected COUNT=6 within 30 cycles");
    applyStimulus(A_CTRL, 32'd0, 4'hF);
    for (int c = 0; c < 4; c++) begin
      expect_reg($sformatf("dis_count_frozen_c%0d", c), A_COUNT, 32'd5);
      expect_irq($sformatf("dis_irq_c%0d", c), 1'b0);
      checkOutput;
      tick;
    end
    applyStimulus(A_CTRL, 32'd1, 4'hF);
    tick;
    expect_reg("dis_count_before_load", A_COUNT, 32'd5);
    checkOutput;
    tick;
    expect_reg("dis_count_reload", A_COUNT, 32'd10);
    checkOutput;
    applyStimulus(A_CTRL, 32'd0, 4'hF);
    repeat (2) tick;

    $display("[TB] CTRL write in INT cycle");
    applyStimulus(A_PRESET, 32'd2, 4'hF);
    applyStimulus(A_CTRL, 32'd9, 4'hF);
    repeat (4) tick;
    expect_irq("col_irq_e4", 1'b1);
    checkOutput;
    applyStimulus(A_CTRL, 32'd9, 4'hF);
    expect_reg("col_ctrl_kept", A_CTRL, 32'd9);
    expect_irq("col_irq_cleared", 1'b0);
    checkOutput;
    tick;
    tick;
    expect_reg("col_count_reload", A_COUNT, 32'd2);
    expect_irq("col_irq_counting", 1'b0);
    checkOutput;
    tick;
    tick;
    expect_irq("col_irq_again", 1'b1);
    expect_reg("col_count_zero", A_COUNT, 32'd0);
    checkOutput;
    tick;
    expect_reg("col_ctrl_oneshot_end", A_CTRL, 32'd8);
    checkOutput;
    applyStimulus(A_CTRL, 32'd0, 4'hF);

    $display("[TB] reset mid-count");
    applyStimulus(A_PRESET, 32'd5, 4'hF);
    applyStimulus(A_CTRL, 32'd9, 4'hF);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      expect_irq($sformatf("rmid_irq_c%0d", c), 1'b0);
      checkOutput;
      tick;
    end
    expect_reg("rmid_ctrl",   A_CTRL,   32'd0);
    expect_reg("rmid_preset", A_PRESET, 32'd0);
    expect_reg("rmid_count",  A_COUNT,  32'd0);
    checkOutput;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
